psx_controller: RTL
===================

Name: psx_controller

Overview:
Emulates a digital PSX gamepad: the responder end of the console-to-pad poll link. It is used as a bench model and as an FPGA-side pad for bridging other inputs to a real console. It oversamples psx_clk/cmd/att on the system clock and shifts out the 5-byte digital poll response LSB-first on data. It also generates the per-byte ack pulse and reports each completed poll.

Parameters:
CTRL_ID, 8'h41, ID byte returned during byte 1 (digital pad)
ACK_DELAY, 4, clk cycles from the byte's 8th psx_clk rising edge (synced) to ack assertion
ACK_WIDTH, 2, clk cycles ack is held low
SYNC_STAGES, 2, synchronizer depth on psx_clk, cmd, att

Ports:
clk  input  1  system clock; must be >= 8x psx_clk frequency
rst_n  input  1  asynchronous active-low reset
psx_clk  input  1  console serial clock, idles high
cmd  input  1  console command bit, sampled on psx_clk rise
att  input  1  active-low frame select from console
button_state  input  16  active-low buttons; [7:0] = byte 3, [15:8] = byte 4
data  output  1  pad response bit; 1 = released/high
ack  output  1  active-low byte acknowledge
poll_done  output  1  one-clk pulse after a complete valid 5-byte poll
frame_error  output  1  one-clk pulse when a frame is aborted or rejected

Behaviour:
- Reset (async, rst_n low): data=1, ack=1, poll_done=0, frame_error=0, state=IDLE, byte_idx=0, bit_idx=0. Synchronizers preset to 1.
- All control uses the synchronized signals. Edge detect is a registered compare of the synced psx_clk.
- Response bytes: 0=8'hFF, 1=CTRL_ID, 2=8'h5A, 3=btn_lat[7:0], 4=btn_lat[15:8].
- Expected cmd bytes: 0=8'h01, 1=8'h42; bytes 2-4 are don't-care.
- btn_lat captures button_state on the clk of the synced att falling edge. It stays stable for the whole frame.
- IDLE: on synced att fall -> SHIFT with byte_idx=0, bit_idx=0.
- SHIFT:
  - On psx_clk fall, data <= resp[byte_idx][bit_idx].
  - On psx_clk rise, cmd is shifted into rx[7] (right shift, LSB-first) and bit_idx increments.
  - After the 8th rise: rx is complete.
  - If byte_idx=0 and rx!=8'h01, or byte_idx=1 and rx!=8'h42: -> IGNORE and pulse frame_error.
  - Else if byte_idx<4: -> ACK_WAIT.
  - Else (byte_idx=4): -> DONE and pulse poll_done. No ack after the last byte.
- ACK_WAIT: count ACK_DELAY clks, then ack <= 0 -> ACK_PULSE.
- ACK_PULSE: hold ack low ACK_WIDTH clks, then ack <= 1, byte_idx+1, bit_idx=0 -> SHIFT.
- psx_clk edges arriving during ACK_WAIT/ACK_PULSE: ack is cut short (ack <= 1), the state advances to SHIFT, and that edge is processed as bit 0 of the next byte.
- DONE / IGNORE: data=1, ack=1; wait for synced att rise -> IDLE.
- Synced att rise in SHIFT/ACK_WAIT/ACK_PULSE:
  - Immediately data=1, ack=1 -> IDLE.
  - frame_error pulses only if byte_idx<4 or bit_idx!=0.
- att rise and a psx_clk edge in the same clk: att wins.
- data returns to 1 on the clk after the synced att rise in every state.
- Latency: data changes SYNC_STAGES+1 clks after the pin falling edge. ack asserts SYNC_STAGES+1+ACK_DELAY clks after the 8th pin rising edge.

Decomposition:
- Shared package psx_pkg:
  - localparams PSX_CMD_START=8'h01, PSX_CMD_POLL=8'h42, PSX_PAD_READY=8'h5A, PSX_ID_DIGITAL=8'h41
  - state encoding for IDLE/SHIFT/ACK_WAIT/ACK_PULSE/DONE/IGNORE
  - a byte-count constant of 5; psx_console uses the same constants
- One sub-module, psx_sync: an N-stage synchronizer with reset preset to 1, instantiated for psx_clk, cmd and att.

Test Plan:
- Nominal poll:
  - Stimulus: clk 2MHz, psx_clk 250kHz, cmd bytes 01 42 00 00 00, button_state=16'hFFFE.
  - Required: data bytes FF 41 5A FE FF; 4 ack pulses, each 2 clks low and 4 clks after each byte's 8th rise; poll_done pulses once after byte 4; no ack after byte 4.
- Bad start byte:
  - Stimulus: cmd byte 0 = 8'h81.
  - Required: frame_error pulses; no ack; data stays 1 until att rises; next valid frame responds normally.
- Button latch:
  - Stimulus: button_state changes 16'hFFFF->16'h0000 mid-frame after att fall.
  - Required: bytes 3/4 read FF FF; the next frame returns 00 00.
- Abort mid-byte:
  - Stimulus: att rises after 3 bits of byte 2.
  - Required: data=1, ack=1 within SYNC_STAGES+1 clks; frame_error pulses; no poll_done.
- Reset mid-ack:
  - Stimulus: rst_n low during ACK_PULSE.
  - Required: ack=1 and data=1 immediately (asynchronous); IDLE after release; the next frame is fully correct.
- Fast console:
  - Stimulus: console clocks byte 1 bit 0 during ACK_WAIT.
  - Required: no ack for byte 0; byte 1 still reads 41 and the frame completes with poll_done.

Source files
------------

// File: rtl/psx_pkg.sv
// Shared constants and types for the PSX pad link (responder and console models).
package psx_pkg;

   localparam logic [7:0] PSX_CMD_START  = 8'h01;
   localparam logic [7:0] PSX_CMD_POLL   = 8'h42;
   localparam logic [7:0] PSX_PAD_READY  = 8'h5A;
   localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;

   // A digital poll is five bytes long on both sides of the link.
   localparam int         PSX_NUM_BYTES  = 5;
   localparam logic [2:0] PSX_LAST_BYTE  = 3'(PSX_NUM_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT     = 3'd1,
      ST_ACK_WAIT  = 3'd2,
      ST_ACK_PULSE = 3'd3,
      ST_DONE      = 3'd4,
      ST_IGNORE    = 3'd5
   } psx_state_e;

   // Pad response byte for a given position in the poll.
   function automatic logic [7:0] psx_resp_byte(input logic [2:0]  idx,
                                                input logic [7:0]  id,
                                                input logic [15:0] btn);
      logic [7:0] r;
      case (idx)
         3'd0:    r = 8'hFF;
         3'd1:    r = id;
         3'd2:    r = PSX_PAD_READY;
         3'd3:    r = btn[7:0];
         3'd4:    r = btn[15:8];
         default: r = 8'hFF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/psx_sync.sv
// N-stage synchronizer for the console pins; presets to 1 (the idle level of every PSX line).
module psx_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the pin value one stage deeper each clk.
   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d;
   end

   // Synchronizer flops, held at the idle-high level during reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/psx_controller.sv
// Digital PSX gamepad responder: oversamples the console link and returns the 5-byte poll.
module psx_controller
   import psx_pkg::*;
#(
   parameter logic [7:0] CTRL_ID     = 8'h41,
   parameter int         ACK_DELAY   = 4,
   parameter int         ACK_WIDTH   = 2,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psx_clk,
   input  logic        cmd,
   input  logic        att,
   input  logic [15:0] button_state,
   output logic        data,
   output logic        ack,
   output logic        poll_done,
   output logic        frame_error
);

   localparam logic [7:0] ACK_DELAY_LAST = 8'(ACK_DELAY - 1);
   localparam logic [7:0] ACK_WIDTH_LAST = 8'(ACK_WIDTH - 1);

   logic clk_s, cmd_s, att_s;

   psx_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (.clk(clk), .rst_n(rst_n), .d(psx_clk), .q(clk_s));
   psx_sync #(.STAGES(SYNC_STAGES)) u_sync_cmd (.clk(clk), .rst_n(rst_n), .d(cmd),     .q(cmd_s));
   psx_sync #(.STAGES(SYNC_STAGES)) u_sync_att (.clk(clk), .rst_n(rst_n), .d(att),     .q(att_s));

   logic        clk_prev_q, clk_prev_d;
   logic        att_prev_q, att_prev_d;
   psx_state_e  state_q, state_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   // Only the seven most recent cmd bits are stored; the eighth is taken live
   // from cmd_s on the completing rise.
   logic [6:0]  rx_q, rx_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] btn_lat_q, btn_lat_d;
   logic        data_q, data_d;
   logic        ack_q, ack_d;
   logic        poll_done_q, poll_done_d;
   logic        frame_error_q, frame_error_d;

   logic        clk_rise, clk_fall, clk_edge;
   logic        att_rise, att_fall;
   logic        do_step, do_abort;
   logic [2:0]  step_byte, step_bit;
   logic [7:0]  resp_cur;
   logic [7:0]  rx_full;

   assign clk_prev_d = clk_s;
   assign att_prev_d = att_s;
   assign clk_rise   =  clk_s & ~clk_prev_q;
   assign clk_fall   = ~clk_s &  clk_prev_q;
   assign clk_edge   = clk_rise | clk_fall;
   assign att_rise   =  att_s & ~att_prev_q;
   assign att_fall   = ~att_s &  att_prev_q;

   // Next-state and output logic: frame sequencing, bit shifting and ack timing.
   always_comb begin
      state_d       = state_q;
      byte_idx_d    = byte_idx_q;
      bit_idx_d     = bit_idx_q;
      rx_d          = rx_q;
      cnt_d         = cnt_q;
      btn_lat_d     = btn_lat_q;
      data_d        = data_q;
      ack_d         = ack_q;
      poll_done_d   = 1'b0;
      frame_error_d = 1'b0;
      do_step       = 1'b0;
      do_abort      = 1'b0;
      step_byte     = byte_idx_q;
      step_bit      = bit_idx_q;
      resp_cur      = 8'hFF;
      rx_full       = {cmd_s, rx_q};

      unique case (state_q)
         ST_IDLE: begin
            data_d = 1'b1;
            ack_d  = 1'b1;
            if (att_fall) begin
               state_d    = ST_SHIFT;
               byte_idx_d = 3'd0;
               bit_idx_d  = 3'd0;
               btn_lat_d  = button_state;
            end
         end
         ST_SHIFT: begin
            if (att_rise) begin
               do_abort = 1'b1;
            end else if (clk_edge) begin
               do_step = 1'b1;
            end
         end
         ST_ACK_WAIT: begin
            if (att_rise) begin
               do_abort = 1'b1;
            end else if (clk_edge) begin
               // Console is already clocking the next byte: drop the ack and
               // treat this edge as its bit 0.
               ack_d     = 1'b1;
               step_byte = byte_idx_q + 3'd1;
               step_bit  = 3'd0;
               do_step   = 1'b1;
            end else if (cnt_q == ACK_DELAY_LAST) begin
               ack_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = ST_ACK_PULSE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_ACK_PULSE: begin
            if (att_rise) begin
               do_abort = 1'b1;
            end else if (clk_edge) begin
               ack_d     = 1'b1;
               step_byte = byte_idx_q + 3'd1;
               step_bit  = 3'd0;
               do_step   = 1'b1;
            end else if (cnt_q == ACK_WIDTH_LAST) begin
               ack_d      = 1'b1;
               byte_idx_d = byte_idx_q + 3'd1;
               bit_idx_d  = 3'd0;
               state_d    = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE, ST_IGNORE: begin
            data_d = 1'b1;
            ack_d  = 1'b1;
            if (att_rise) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Console deselected mid-frame: release the lines at once.
      if (do_abort) begin
         state_d       = ST_IDLE;
         data_d        = 1'b1;
         ack_d         = 1'b1;
         frame_error_d = (byte_idx_q < PSX_LAST_BYTE) || (bit_idx_q != 3'd0);
      end

      // One psx_clk edge: drive the next response bit on a fall, capture cmd on a rise.
      if (do_step) begin
         state_d    = ST_SHIFT;
         byte_idx_d = step_byte;
         resp_cur   = psx_resp_byte(step_byte, CTRL_ID, btn_lat_q);
         if (clk_fall) begin
            data_d    = resp_cur[step_bit];
            bit_idx_d = step_bit;
         end else begin
            rx_d      = rx_full[7:1];
            bit_idx_d = step_bit + 3'd1;
            if (step_bit == 3'd7) begin
               if (((step_byte == 3'd0) && (rx_full != PSX_CMD_START)) ||
                   ((step_byte == 3'd1) && (rx_full != PSX_CMD_POLL))) begin
                  state_d       = ST_IGNORE;
                  frame_error_d = 1'b1;
                  data_d        = 1'b1;
                  ack_d         = 1'b1;
               end else if (step_byte < PSX_LAST_BYTE) begin
                  state_d = ST_ACK_WAIT;
                  cnt_d   = 8'd0;
               end else begin
                  // Last byte is never acknowledged.
                  state_d     = ST_DONE;
                  poll_done_d = 1'b1;
                  data_d      = 1'b1;
               end
            end
         end
      end
   end

   // State and output registers; lines return to their idle-high level on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_prev_q    <= 1'b1;
         att_prev_q    <= 1'b1;
         state_q       <= ST_IDLE;
         byte_idx_q    <= 3'd0;
         bit_idx_q     <= 3'd0;
         rx_q          <= 7'd0;
         cnt_q         <= 8'd0;
         btn_lat_q     <= 16'hFFFF;
         data_q        <= 1'b1;
         ack_q         <= 1'b1;
         poll_done_q   <= 1'b0;
         frame_error_q <= 1'b0;
      end else begin
         clk_prev_q    <= clk_prev_d;
         att_prev_q    <= att_prev_d;
         state_q       <= state_d;
         byte_idx_q    <= byte_idx_d;
         bit_idx_q     <= bit_idx_d;
         rx_q          <= rx_d;
         cnt_q         <= cnt_d;
         btn_lat_q     <= btn_lat_d;
         data_q        <= data_d;
         ack_q         <= ack_d;
         poll_done_q   <= poll_done_d;
         frame_error_q <= frame_error_d;
      end
   end

   assign data        = data_q;
   assign ack         = ack_q;
   assign poll_done   = poll_done_q;
   assign frame_error = frame_error_q;

endmodule
